mem_rmw_controller: RTL
=======================

MEM_RMW_CONTROLLER -- requirements
Module: mem_rmw_controller

Interface
REQ-001 Parameter WORD, default `WORD (64), data and address width.
REQ-002 Parameter SIZE_W, default 2, access-size code width.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 req_valid  input  1  requester presents an access.
REQ-006 req_ready  output  1  controller accepts an access this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_size  input  SIZE_W  00 byte, 01 half, 10 word(32), 11 double(64).
REQ-009 req_address  input  WORD  byte address.
REQ-010 req_wdata  input  WORD  store data, right-justified.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_err  output  1  misaligned access, qualified by resp_valid.
REQ-013 resp_rdata  output  WORD  zero-extended load data, qualified by resp_valid.
REQ-014 mem_read  output  1  read strobe to data_memory.
REQ-015 mem_write  output  1  write strobe to data_memory.
REQ-016 mem_address  output  WORD  doubleword-aligned address, {req_address[WORD-1:3],3'b000}.
REQ-017 mem_wdata  output  WORD  full doubleword to write.
REQ-018 mem_rdata  input  WORD  data_memory output, valid the cycle after mem_read.

Function
REQ-019 FSM states: IDLE, READ, WAIT, WRITE, RESP.
REQ-020 req_ready SHALL be 1 only in IDLE; handshake = req_valid & req_ready.
REQ-021 On handshake, request fields SHALL be latched; later changes on req_* are ignored until the next IDLE.
REQ-022 Misaligned (address[2:0] not a multiple of size bytes): IDLE->RESP, resp_err=1, no mem_read/mem_write.
REQ-023 Aligned load or aligned sub-double store: IDLE->READ.
REQ-024 Aligned double store: IDLE->WRITE, no read.
REQ-025 READ: mem_read=1 for exactly one cycle; ->WAIT.
REQ-026 WAIT: capture mem_rdata; load ->RESP, store ->WRITE.
REQ-027 Load extraction: lane = mem_rdata >> (8*address[2:0]), masked to size, zero-extended to WORD.
REQ-028 Store merge: bytes address[2:0]..address[2:0]+size_bytes-1 replaced by low bytes of req_wdata; all other bytes preserved from captured mem_rdata.
REQ-029 WRITE: mem_write=1 for exactly one cycle with mem_wdata; ->RESP.
REQ-030 RESP: resp_valid=1 for exactly one cycle; ->IDLE.
REQ-031 Latency from handshake to resp_valid: load 3 cycles, sub-double store 4, double store 2, error 1.
REQ-032 mem_read and mem_write SHALL never be asserted in the same cycle.
REQ-033 resp_rdata SHALL be 0 for stores and errors.
REQ-034 Back-to-back: a new handshake is possible the cycle after RESP (IDLE); throughput is at most one access per latency+1 cycles.

Reset
REQ-035 reset=0 at a clock edge: state->IDLE; req_ready=1; resp_valid, resp_err, mem_read, mem_write=0; resp_rdata, mem_wdata, latched request=0.
REQ-036 Reset mid-operation SHALL abort the access; a store aborted before WRITE SHALL leave memory unchanged.
REQ-037 reset dominates all other inputs in the same cycle.

Structure
REQ-038 Size codes, state encoding and the WORD constant SHALL live in constants.vh.
REQ-039 Combinational extract/merge SHALL be a sub-module lane_merge (inputs rdata, wdata, offset, size; outputs load_data, merged_data).
REQ-040 All registered state SHALL sit in mem_rmw_controller.

Verification
REQ-041 Memory at 0x10 = 0x1122334455667788; byte store 0xAB at 0x13 -> single mem_write of 0x11223344AB667788 at 0x10, resp_valid 4 cycles after handshake.
REQ-042 Same memory; half load at 0x12 -> resp_rdata=0x0000000000005566, resp_err=0, 3 cycles.
REQ-043 Half store at 0x11 -> resp_err=1 after 1 cycle, no mem_read/mem_write, memory unchanged.
REQ-044 Double store 0xDEADBEEFCAFEF00D at 0x18 -> no mem_read, mem_write at 0x18, resp_valid after 2 cycles.
REQ-045 reset=0 during WAIT of a word store at 0x20 -> no mem_write, outputs at reset values, memory at 0x20 unchanged.
REQ-046 req_valid held high with varying req_* -> req_ready low outside IDLE, each access completes with its latched fields.

Source files
------------

// File: rtl/mem_rmw_controller_pkg.sv
// Shared constants for the read-modify-write memory controller: widths,
// access-size codes, FSM state encoding and lane helper functions.
package mem_rmw_controller_pkg;

  localparam int DEFAULT_WORD   = 64;
  localparam int DEFAULT_SIZE_W = 2;

  typedef enum logic [1:0] {
    SIZE_BYTE   = 2'b00,
    SIZE_HALF   = 2'b01,
    SIZE_WORD   = 2'b10,
    SIZE_DOUBLE = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // Low-order byte mask covering one access of the given size.
  function automatic logic [63:0] lane_mask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: lane_mask = 64'h0000_0000_0000_00FF;
      SIZE_HALF: lane_mask = 64'h0000_0000_0000_FFFF;
      SIZE_WORD: lane_mask = 64'h0000_0000_FFFF_FFFF;
      default:   lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // An access is misaligned when its offset is not a multiple of its size.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] offset);
    case (size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = offset[0];
      SIZE_WORD: misaligned = |offset[1:0];
      default:   misaligned = |offset;
    endcase
  endfunction

endpackage

// File: rtl/mem_rmw_controller_lane_merge.sv
// Combinational lane logic: extracts a load lane from a doubleword and merges
// store data into a doubleword at the addressed byte offset.
module lane_merge
  import mem_rmw_controller_pkg::*;
#(
  parameter int WORD   = DEFAULT_WORD,
  parameter int SIZE_W = DEFAULT_SIZE_W
) (
  input  logic [WORD-1:0]   rdata,
  input  logic [WORD-1:0]   wdata,
  input  logic [2:0]        offset,
  input  logic [SIZE_W-1:0] size,
  output logic [WORD-1:0]   load_data,
  output logic [WORD-1:0]   merged_data
);

  logic [5:0]      shamt_s;
  logic [WORD-1:0] mask_s;
  logic [WORD-1:0] shifted_mask_s;

  // Shift the lane to/from the addressed byte and splice it over the old data.
  always_comb begin
    shamt_s        = {offset, 3'b000};
    mask_s         = WORD'(lane_mask(size[1:0]));
    shifted_mask_s = mask_s << shamt_s;
    load_data      = (rdata >> shamt_s) & mask_s;
    merged_data    = (rdata & ~shifted_mask_s) | ((wdata & mask_s) << shamt_s);
  end

endmodule

// File: rtl/mem_rmw_controller.sv
// Sub-doubleword load/store controller in front of a doubleword-wide memory;
// stores narrower than a doubleword are done as read-modify-write.
module mem_rmw_controller
  import mem_rmw_controller_pkg::*;
#(
  parameter int WORD   = DEFAULT_WORD,
  parameter int SIZE_W = DEFAULT_SIZE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [SIZE_W-1:0] req_size,
  input  logic [WORD-1:0]   req_address,
  input  logic [WORD-1:0]   req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [WORD-1:0]   resp_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [WORD-1:0]   mem_address,
  output logic [WORD-1:0]   mem_wdata,
  input  logic [WORD-1:0]   mem_rdata
);

  state_e            state_r, state_s;
  logic              write_r;
  logic [SIZE_W-1:0] size_r;
  logic [WORD-1:0]   address_r, wdata_r;
  logic              req_ready_r, resp_valid_r, resp_err_r, mem_read_r, mem_write_r;
  logic [WORD-1:0]   resp_rdata_r, mem_wdata_r;

  logic              handshake_s, misaligned_s, resp_err_s;
  logic              mem_read_s, mem_write_s, resp_valid_s;
  logic [WORD-1:0]   resp_rdata_s, mem_wdata_s, load_data_s, merged_data_s;

  lane_merge #(.WORD(WORD), .SIZE_W(SIZE_W)) u_lane_merge (
    .rdata       (mem_rdata),
    .wdata       (wdata_r),
    .offset      (address_r[2:0]),
    .size        (size_r),
    .load_data   (load_data_s),
    .merged_data (merged_data_s)
  );

  // Next-state decode and next values of the registered outputs.
  always_comb begin
    state_s      = state_r;
    handshake_s  = req_valid & req_ready_r;
    misaligned_s = misaligned(req_size[1:0], req_address[2:0]);
    resp_err_s   = 1'b0;
    resp_rdata_s = '0;
    mem_wdata_s  = mem_wdata_r;
    case (state_r)
      ST_IDLE: begin
        if (handshake_s) begin
          if (misaligned_s) begin
            state_s    = ST_RESP;
            resp_err_s = 1'b1;
          end else if (req_write && (req_size[1:0] == SIZE_DOUBLE)) begin
            state_s     = ST_WRITE;
            mem_wdata_s = req_wdata;
          end else begin
            state_s = ST_READ;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ:  state_s = ST_WAIT;
      ST_WAIT: begin
        // mem_rdata is valid only now; it is consumed directly, never re-read.
        if (write_r) begin
          state_s     = ST_WRITE;
          mem_wdata_s = merged_data_s;
        end else begin
          state_s      = ST_RESP;
          resp_rdata_s = load_data_s;
        end
      end
      ST_WRITE: state_s = ST_RESP;
      ST_RESP:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
    mem_read_s   = (state_s == ST_READ);
    mem_write_s  = (state_s == ST_WRITE);
    resp_valid_s = (state_s == ST_RESP);
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      write_r      <= 1'b0;
      size_r       <= '0;
      address_r    <= '0;
      wdata_r      <= '0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= '0;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      mem_wdata_r  <= '0;
    end else begin
      state_r      <= state_s;
      req_ready_r  <= (state_s == ST_IDLE);
      resp_valid_r <= resp_valid_s;
      resp_err_r   <= resp_err_s;
      resp_rdata_r <= resp_rdata_s;
      mem_read_r   <= mem_read_s;
      mem_write_r  <= mem_write_s;
      mem_wdata_r  <= mem_wdata_s;
      if (handshake_s) begin
        write_r   <= req_write;
        size_r    <= req_size;
        address_r <= req_address;
        wdata_r   <= req_wdata;
      end
    end
  end

  assign req_ready   = req_ready_r;
  assign resp_valid  = resp_valid_r;
  assign resp_err    = resp_err_r;
  assign resp_rdata  = resp_rdata_r;
  assign mem_read    = mem_read_r;
  assign mem_write   = mem_write_r;
  assign mem_wdata   = mem_wdata_r;
  assign mem_address = {address_r[WORD-1:3], 3'b000};

endmodule
